// File: rtl/muldiv_iter_unit.sv
// Radix-2 iterative multiply/divide unit that sits in EX beside the single-cycle ALU.
// Optional feature macro: MULDIV_ACC_EN enables MADD/MADDU/MSUB/MSUBU and adds an ACC state.
module muldiv_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   acc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero,
    output logic                 busy
);
    // Handshake rule for both channels: a transfer happens on the rising edge where valid and
    // ready are both high; the producer holds valid and its payload stable until that edge.
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int DW    = 2 * WIDTH + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
`ifdef MULDIV_ACC_EN
    localparam logic [2:0] S_ACC  = 3'd4;
`endif
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [DW-1:0]      p;
    logic [WIDTH-1:0]   mop;
    logic [WIDTH-1:0]   a_q;
    logic               sa_q;
    logic               sb_q;
    logic               div_q;
    logic               bz_q;
    logic [2*WIDTH-1:0] result_q;
    logic               dbz_q;

`ifdef MULDIV_ACC_EN
    logic               acc_op_q;
    logic               sub_q;
    logic [2*WIDTH-1:0] acc_q;
`else
    logic unused_acc;
    assign unused_acc = ^acc_in;
`endif

    // op[0]=1 selects the unsigned flavour of every operation
    logic             is_signed_in;
    logic             is_div_in;
    logic             sa_in;
    logic             sb_in;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign is_signed_in = ~op[0];
    assign is_div_in    = (op[2:1] == 2'b01);
    assign sa_in        = is_signed_in & a[WIDTH-1];
    assign sb_in        = is_signed_in & b[WIDTH-1];
    assign mag_a        = sa_in ? -a : a;
    assign mag_b        = sb_in ? -b : b;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic [DW-1:0]    mul_next;
    logic [DW-1:0]    div_next;

    // p holds {partial, multiplier} for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum   = p[DW-1:WIDTH] + {1'b0, mop};
        mul_next  = p[0] ? {1'b0, mul_sum, p[WIDTH-1:1]} : {1'b0, p[DW-1:1]};
        div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mop};
        div_next  = div_diff[WIDTH+1] ? {div_shift, p[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH:0], p[WIDTH-2:0], 1'b1};
    end

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [2*WIDTH-1:0] div_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // Most-negative / -1 falls out naturally: |q| = 2^(WIDTH-1) with equal signs, remainder 0.
    always_comb begin
        prod     = p[2*WIDTH-1:0];
        prod_fix = (sa_q ^ sb_q) ? -prod : prod;
        quo      = p[WIDTH-1:0];
        rem      = p[2*WIDTH-1:WIDTH];
        if (bz_q) begin
            div_fix = {a_q, {WIDTH{1'b1}}};
        end else begin
            div_fix = {(sa_q ? -rem : rem), ((sa_q ^ sb_q) ? -quo : quo)};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            p        <= '0;
            mop      <= '0;
            a_q      <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            div_q    <= 1'b0;
            bz_q     <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
`ifdef MULDIV_ACC_EN
            acc_op_q <= 1'b0;
            sub_q    <= 1'b0;
            acc_q    <= '0;
`endif
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
            dbz_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        sa_q  <= sa_in;
                        sb_q  <= sb_in;
                        div_q <= is_div_in;
                        bz_q  <= (b == '0);
                        cnt   <= '0;
                        dbz_q <= 1'b0;
`ifdef MULDIV_ACC_EN
                        acc_op_q <= op[2];
                        sub_q    <= op[1];
                        acc_q    <= acc_in;
`endif
                        if (is_div_in) begin
                            p     <= {{(WIDTH+1){1'b0}}, mag_a};
                            mop   <= mag_b;
                            state <= S_DIV;
                        end else begin
                            p     <= {{(WIDTH+1){1'b0}}, mag_b};
                            mop   <= mag_a;
                            state <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    p   <= mul_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end
                end
                S_DIV: begin
                    p   <= div_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt   <= '0;
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= div_q ? div_fix : prod_fix;
                    dbz_q    <= div_q & bz_q;
`ifdef MULDIV_ACC_EN
                    state    <= acc_op_q ? S_ACC : S_DONE;
`else
                    state    <= S_DONE;
`endif
                end
`ifdef MULDIV_ACC_EN
                S_ACC: begin
                    result_q <= sub_q ? (acc_q - result_q) : (acc_q + result_q);
                    state    <= S_DONE;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                        dbz_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state == S_IDLE);
    assign busy        = ~in_ready;
    assign out_valid   = (state == S_DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule
